// File: rtl/spi_frame_if.sv
// spi_frame_if: word handshake plus SPI pins for spi_frame_master.
// master = the SPI initiator block, slave = the user/pin side.
interface spi_frame_if #(
  parameter int MSB = 16
);
  logic           tx_valid;
  logic           tx_ready;
  logic [MSB-1:0] tx_data;
  logic           rx_valid;
  logic [MSB-1:0] rx_data;
  logic           busy;
  logic           spi_cs;
  logic           spi_clk;
  logic           spi_mosi;
  logic           spi_miso;

  modport master (
    input  tx_valid, tx_data, spi_miso,
    output tx_ready, rx_valid, rx_data, busy,
    output spi_cs, spi_clk, spi_mosi
  );

  modport slave (
    output tx_valid, tx_data, spi_miso,
    input  tx_ready, rx_valid, rx_data, busy,
    input  spi_cs, spi_clk, spi_mosi
  );
endinterface

// File: rtl/spi_frame_master.sv
// spi_frame_master: SPI initiator, one MSB-bit frame per accepted word.
// MOSI shifts out MSB-first; MISO is sampled on each rising SCLK.
module spi_frame_master #(
  parameter int MSB     = 16,
  parameter int CLK_DIV = 4
) (
  input logic clk,
  input logic rst,
  spi_frame_if.master bus
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (MSB > 2) ? $clog2(MSB) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] HI    = 3'd2;
  localparam logic [2:0] LO    = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;
  localparam logic [2:0] GAP   = 3'd5;

  logic [2:0]     state;
  logic [PW-1:0]  ph;
  logic [BW-1:0]  bit_cnt;
  logic [MSB-1:0] tx_sh;
  logic [MSB-1:0] rx_sh;
  logic [MSB-1:0] rxd;
  logic           cs;
  logic           sclk;
  logic           mosi;
  logic           ready;
  logic           bsy;
  logic           rxv;
  logic           ph_end;
  logic           last;

  assign ph_end = (ph == PW'(CLK_DIV - 1));
  assign last   = (bit_cnt == BW'(MSB - 1));

  assign bus.spi_cs   = cs;
  assign bus.spi_clk  = sclk;
  assign bus.spi_mosi = mosi;
  assign bus.tx_ready = ready;
  assign bus.busy     = bsy;
  assign bus.rx_valid = rxv;
  assign bus.rx_data  = rxd;

  // Phase counter: times every non-IDLE state to CLK_DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph <= '0;
    end else if (state == IDLE || ph_end) begin
      ph <= '0;
    end else begin
      ph <= ph + 1'b1;
    end
  end

  // Frame sequencer: drives CS/SCLK/MOSI and captures MISO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cs      <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      ready   <= 1'b1;
      bsy     <= 1'b0;
      rxv     <= 1'b0;
      rxd     <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      bit_cnt <= '0;
    end else begin
      rxv <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.tx_valid && ready) begin
            tx_sh   <= bus.tx_data;
            rx_sh   <= '0;
            bit_cnt <= '0;
            cs      <= 1'b0;
            mosi    <= bus.tx_data[MSB-1];
            ready   <= 1'b0;
            bsy     <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP, LO: begin
          if (ph_end) begin
            sclk  <= 1'b1;
            rx_sh <= {rx_sh[MSB-2:0], bus.spi_miso};
            state <= HI;
          end
        end
        HI: begin
          if (ph_end) begin
            sclk <= 1'b0;
            if (last) begin
              state <= HOLD;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              mosi    <= tx_sh[MSB-2];
              tx_sh   <= {tx_sh[MSB-2:0], 1'b0};
              state   <= LO;
            end
          end
        end
        HOLD: begin
          if (ph_end) begin
            cs    <= 1'b1;
            rxd   <= rx_sh;
            rxv   <= 1'b1;
            state <= GAP;
          end
        end
        GAP: begin
          if (ph_end) begin
            ready <= 1'b1;
            bsy   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
